// File: rtl/zy_net.sv
// Fully-connected classifier: weights/biases loaded over AXI4-Lite, pixels streamed in,
// every neuron accumulated in parallel, then a sequential argmax raises a one-cycle intr.
module zy_net #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_INPUTS  = 784,
  parameter int NUM_OUTPUTS = 10,
  parameter int FRAC_BITS   = 8
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic [31:0]           s_axi_awaddr,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [31:0]           s_axi_araddr,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  input  logic [DATA_WIDTH-1:0] axis_in_data,
  input  logic                  axis_in_data_valid,
  output logic                  axis_in_data_ready,
  output logic                  intr
);

  localparam int IW     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int PW     = $clog2(NUM_INPUTS + 1);
  localparam int NW     = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
  localparam int ACC_W  = 32;
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'((64'sd1 <<< (DATA_WIDTH-1)) - 64'sd1);
  localparam logic signed [ACC_W:0] SAT_LO = -SAT_HI - (ACC_W+1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_FINAL, S_ARGMAX, S_DONE} state_t;

  state_t state_q, state_d;

  logic [31:0]                  layer_q, neuron_q;
  logic                         soft_rst_q;
  logic [PW-1:0]                wptr_q;
  logic [NW-1:0]                rptr_q, scan_q, best_idx_q, class_q;
  logic [IW-1:0]                pix_cnt_q;
  logic                         done_q, busy, beat, last_beat, take_new;
  logic                         wr_fire, rd_fire, sel_ok, wt_ok;
  logic [2:0]                   wr_sel, rd_sel;
  logic [31:0]                  rd_mux;
  logic signed [DATA_WIDTH-1:0] w_mem [NUM_OUTPUTS][NUM_INPUTS];
  logic signed [DATA_WIDTH-1:0] b_mem [NUM_OUTPUTS];
  logic signed [DATA_WIDTH-1:0] nout  [NUM_OUTPUTS];
  logic signed [DATA_WIDTH-1:0] best_val;
  logic signed [ACC_W-1:0]      acc   [NUM_OUTPUTS];
  logic                         unused;

  function automatic logic signed [ACC_W-1:0] scale_prod(input logic signed [DATA_WIDTH-1:0] x,
                                                         input logic signed [DATA_WIDTH-1:0] w);
    logic signed [PROD_W-1:0] p;
    p = x * w;
    return ACC_W'(p >>> FRAC_BITS);
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] saturate(input logic signed [ACC_W:0] v);
    if (v > SAT_HI)      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (v < SAT_LO) return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else                 return v[DATA_WIDTH-1:0];
  endfunction

  assign unused      = ^{s_axi_awprot, s_axi_arprot, s_axi_wstrb, s_axi_awaddr, s_axi_araddr, s_axi_wdata};
  assign s_axi_bresp = 2'b00;
  assign s_axi_rresp = 2'b00;

  assign wr_fire = s_axi_awready & s_axi_awvalid & s_axi_wvalid;
  assign rd_fire = s_axi_arready & s_axi_arvalid;
  assign wr_sel  = s_axi_awaddr[4:2];
  assign rd_sel  = s_axi_araddr[4:2];
  assign sel_ok  = (layer_q == 32'd1) && (neuron_q < 32'(NUM_OUTPUTS));
  assign wt_ok   = sel_ok && (wptr_q < PW'(NUM_INPUTS));

  // AXI-Lite handshakes and configuration registers
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      layer_q       <= '0;
      neuron_q      <= '0;
      soft_rst_q    <= 1'b1;
      wptr_q        <= '0;
    end else begin
      s_axi_awready <= !s_axi_awready && s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid;
      s_axi_wready  <= !s_axi_awready && s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid;
      if (wr_fire)           s_axi_bvalid <= 1'b1;
      else if (s_axi_bready) s_axi_bvalid <= 1'b0;
      s_axi_arready <= !s_axi_arready && s_axi_arvalid && !s_axi_rvalid;
      if (rd_fire) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_mux;
      end else if (s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
      if (wr_fire) begin
        case (wr_sel)
          3'd0:    if (wt_ok) wptr_q <= wptr_q + PW'(1);
          3'd3:    layer_q <= s_axi_wdata;
          3'd4: begin
            neuron_q <= s_axi_wdata;
            wptr_q   <= '0;
          end
          3'd7:    soft_rst_q <= s_axi_wdata[0];
          default: ;
        endcase
      end
    end
  end

  // Weight and bias storage is deliberately left unreset
  always_ff @(posedge s_axi_aclk) begin
    if (wr_fire && wr_sel == 3'd0 && wt_ok)
      w_mem[neuron_q[NW-1:0]][wptr_q[IW-1:0]] <= s_axi_wdata[DATA_WIDTH-1:0];
    if (wr_fire && wr_sel == 3'd1 && sel_ok)
      b_mem[neuron_q[NW-1:0]] <= s_axi_wdata[DATA_WIDTH-1:0];
  end

  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      3'd2:    rd_mux = 32'(class_q);
      3'd3:    rd_mux = layer_q;
      3'd4:    rd_mux = neuron_q;
      3'd5:    rd_mux = 32'(nout[rptr_q]);
      3'd6:    rd_mux = {30'b0, done_q, busy};
      3'd7:    rd_mux = {31'b0, soft_rst_q};
      default: rd_mux = '0;
    endcase
  end

  assign axis_in_data_ready = !soft_rst_q && (state_q == S_IDLE || state_q == S_ACCUM);
  assign busy      = !soft_rst_q && (state_q == S_ACCUM || state_q == S_FINAL || state_q == S_ARGMAX);
  assign beat      = axis_in_data_valid && axis_in_data_ready;
  assign last_beat = (pix_cnt_q == IW'(NUM_INPUTS - 1));
  assign take_new  = (scan_q == '0) || (nout[scan_q] > best_val);

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) state_q <= S_IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (beat) state_d = last_beat ? S_FINAL : S_ACCUM;
      S_ACCUM:  if (beat && last_beat) state_d = S_FINAL;
      S_FINAL:  state_d = S_ARGMAX;
      S_ARGMAX: if (scan_q == NW'(NUM_OUTPUTS - 1)) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (soft_rst_q) state_d = S_IDLE;
  end

  // Stage boundary: accumulate on each beat, scan outputs, publish class
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      for (int n = 0; n < NUM_OUTPUTS; n++) acc[n] <= '0;
      pix_cnt_q  <= '0;
      scan_q     <= '0;
      best_idx_q <= '0;
      class_q    <= '0;
      done_q     <= 1'b0;
      intr       <= 1'b0;
    end else if (soft_rst_q) begin
      for (int n = 0; n < NUM_OUTPUTS; n++) acc[n] <= '0;
      pix_cnt_q <= '0;
      scan_q    <= '0;
      done_q    <= 1'b0;
      intr      <= 1'b0;
    end else begin
      intr <= (state_q == S_DONE);
      if (beat) begin
        for (int n = 0; n < NUM_OUTPUTS; n++)
          acc[n] <= acc[n] + scale_prod(axis_in_data, w_mem[n][pix_cnt_q]);
        pix_cnt_q <= last_beat ? '0 : pix_cnt_q + IW'(1);
        if (state_q == S_IDLE) done_q <= 1'b0;
      end
      case (state_q)
        S_FINAL: begin
          for (int n = 0; n < NUM_OUTPUTS; n++) acc[n] <= '0;
          scan_q <= '0;
        end
        S_ARGMAX: begin
          if (take_new) best_idx_q <= scan_q;
          scan_q <= scan_q + NW'(1);
        end
        S_DONE: begin
          class_q <= best_idx_q;
          done_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (state_q == S_FINAL)
      for (int n = 0; n < NUM_OUTPUTS; n++)
        nout[n] <= saturate((ACC_W+1)'(acc[n]) + (ACC_W+1)'(b_mem[n]));
    if (state_q == S_ARGMAX && take_new) best_val <= nout[scan_q];
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn)
      rptr_q <= '0;
    else if (beat && state_q == S_IDLE)
      rptr_q <= '0;
    else if (rd_fire && rd_sel == 3'd5)
      rptr_q <= (rptr_q == NW'(NUM_OUTPUTS - 1)) ? '0 : rptr_q + NW'(1);
  end

endmodule

// File: tb/tb_zy_net.sv
// Directed bench for zy_net with 4 inputs, 3 neurons, 8 fractional bits.
module tb_zy_net;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic [15:0] px;
  logic        px_valid, px_ready, intr;

  int chk = 0;
  int pass = 0;
  int intr_count = 0;

  zy_net #(.DATA_WIDTH(16), .NUM_INPUTS(4), .NUM_OUTPUTS(3), .FRAC_BITS(8)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .axis_in_data(px), .axis_in_data_valid(px_valid), .axis_in_data_ready(px_ready),
    .intr(intr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (intr === 1'b1) intr_count++;

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (awready !== 1'b1) begin chk++; $display("FAIL aw_timeout addr %h", a); end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    n = 0;
    @(negedge clk);
    while (bvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (bvalid !== 1'b1) begin chk++; $display("FAIL b_timeout addr %h", a); end
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (arready !== 1'b1) begin chk++; $display("FAIL ar_timeout addr %h", a); end
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    n = 0;
    @(negedge clk);
    while (rvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (rvalid !== 1'b1) begin chk++; $display("FAIL r_timeout addr %h", a); end
    d = rdata;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic set_neuron(input int n, input logic [15:0] w, input logic [15:0] b);
    axi_write(32'h10, n);
    for (int i = 0; i < 4; i++) axi_write(32'h00, {16'h0, w});
    axi_write(32'h04, {16'h0, b});
  endtask

  task automatic send_pixel(input logic [15:0] v);
    int n;
    @(negedge clk);
    px = v; px_valid = 1'b1;
    n = 0;
    while (px_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (px_ready !== 1'b1) begin chk++; $display("FAIL ready_timeout pixel %h", v); end
    @(posedge clk); #1;
    px_valid = 1'b0;
  endtask

  // Streams four equal pixels; reports the cycle of the first intr after the last beat and pulse count
  task automatic run_image(input logic [15:0] v, output int at, output int pulses);
    int base;
    base = intr_count;
    for (int i = 0; i < 4; i++) send_pixel(v);
    at = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (intr === 1'b1 && at == 0) at = k;
    end
    pulses = intr_count - base;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0;
    awaddr = '0; wdata = '0; awprot = '0; wstrb = 4'hF; awvalid = 0; wvalid = 0; bready = 0;
    araddr = '0; arprot = '0; arvalid = 0; rready = 0; px = '0; px_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk++;
    if ({awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, intr} !== 42'h0)
      $display("FAIL reset_axi_outs got %h want 0", {awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, intr});
    else pass++;
    chk++;
    if (px_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", px_ready); else pass++;
    @(negedge clk);
    rst_n = 1'b1;
    axi_read(32'h1C, d);
    chk++;
    if (d !== 32'h1) $display("FAIL reset_soft_reset got %h want 00000001", d); else pass++;
    axi_read(32'h18, d);
    chk++;
    if (d !== 32'h0) $display("FAIL reset_status got %h want 00000000", d); else pass++;
    chk++;
    if (px_ready !== 1'b0) $display("FAIL reset_ready_soft got %b want 0", px_ready); else pass++;
  endtask

  task automatic test_handshake();
    int hi, bad_aw, bad_w;
    logic [31:0] d;
    bad_aw = 0; bad_w = 0; hi = 0;
    @(negedge clk);
    awaddr = 32'h0C; wdata = 32'h1; awvalid = 1'b1; wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (awready !== 1'b0) bad_aw++;
    end
    chk++;
    if (bad_aw != 0) $display("FAIL hs_aw_without_w got %0d high cycles want 0", bad_aw); else pass++;
    wvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (awready === 1'b1) begin
        hi++;
        if (wready !== 1'b1) bad_w++;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
      end
    end
    chk++;
    if (hi != 1) $display("FAIL hs_awready_pulse got %0d cycles want 1", hi); else pass++;
    chk++;
    if (bad_w != 0) $display("FAIL hs_wready_together got %0d misses want 0", bad_w); else pass++;
    chk++;
    if (bvalid !== 1'b1) $display("FAIL hs_bvalid_held got %b want 1", bvalid); else pass++;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    chk++;
    if (bvalid !== 1'b0) $display("FAIL hs_bvalid_drop got %b want 0", bvalid); else pass++;
    axi_read(32'h0C, d);
    chk++;
    if (d !== 32'h1) $display("FAIL hs_layer_written got %h want 00000001", d); else pass++;
  endtask

  task automatic test_inference();
    logic [31:0] d;
    logic [31:0] exp_out [4];
    int at, pulses;
    exp_out = '{32'h0000_0400, 32'h0000_0800, 32'hFFFF_FC00, 32'h0000_0400};
    axi_write(32'h1C, 32'h0);
    axi_write(32'h0C, 32'h1);
    set_neuron(0, 16'h0100, 16'h0000);
    set_neuron(1, 16'h0200, 16'h0000);
    set_neuron(2, 16'hFF00, 16'h0000);
    run_image(16'h0100, at, pulses);
    chk++;
    if (at != 5) $display("FAIL inf_intr_latency got %0d want 5", at); else pass++;
    chk++;
    if (pulses != 1) $display("FAIL inf_intr_pulses got %0d want 1", pulses); else pass++;
    axi_read(32'h08, d);
    chk++;
    if (d !== 32'h1) $display("FAIL inf_class got %h want 00000001", d); else pass++;
    axi_read(32'h18, d);
    chk++;
    if (d !== 32'h2) $display("FAIL inf_status_done got %h want 00000002", d); else pass++;
    for (int i = 0; i < 4; i++) begin
      axi_read(32'h14, d);
      chk++;
      if (d !== exp_out[i]) $display("FAIL inf_neuron_out%0d got %h want %h", i, d, exp_out[i]);
      else pass++;
    end
  endtask

  task automatic test_tie_sat();
    logic [31:0] d;
    logic [31:0] exp_sat [3];
    int at, pulses;
    exp_sat = '{32'h0000_7FFF, 32'hFFFF_8000, 32'h0000_0200};
    set_neuron(0, 16'h0000, 16'h0100);
    set_neuron(1, 16'h0000, 16'h0200);
    set_neuron(2, 16'h0000, 16'h0200);
    run_image(16'h0100, at, pulses);
    axi_read(32'h08, d);
    chk++;
    if (d !== 32'h1) $display("FAIL tie_class got %h want 00000001", d); else pass++;
    axi_read(32'h14, d);
    chk++;
    if (d !== 32'h0000_0100) $display("FAIL tie_neuron_out0 got %h want 00000100", d); else pass++;
    set_neuron(0, 16'h7FFF, 16'h0000);
    set_neuron(1, 16'h8000, 16'h0200);
    run_image(16'h7FFF, at, pulses);
    chk++;
    if (pulses != 1) $display("FAIL sat_intr_pulses got %0d want 1", pulses); else pass++;
    axi_read(32'h08, d);
    chk++;
    if (d !== 32'h0) $display("FAIL sat_class got %h want 00000000", d); else pass++;
    for (int i = 0; i < 3; i++) begin
      axi_read(32'h14, d);
      chk++;
      if (d !== exp_sat[i]) $display("FAIL sat_neuron_out%0d got %h want %h", i, d, exp_sat[i]);
      else pass++;
    end
  endtask

  task automatic test_soft_reset();
    logic [31:0] d;
    logic [31:0] exp_out [3];
    int base, at, pulses;
    exp_out = '{32'h0000_0400, 32'h0000_0800, 32'hFFFF_FC00};
    set_neuron(0, 16'h0100, 16'h0000);
    set_neuron(1, 16'h0200, 16'h0000);
    set_neuron(2, 16'hFF00, 16'h0000);
    base = intr_count;
    send_pixel(16'h0100);
    send_pixel(16'h0100);
    axi_read(32'h18, d);
    chk++;
    if (d !== 32'h1) $display("FAIL sr_status_busy got %h want 00000001", d); else pass++;
    axi_write(32'h1C, 32'h1);
    @(negedge clk);
    chk++;
    if (px_ready !== 1'b0) $display("FAIL sr_ready_drop got %b want 0", px_ready); else pass++;
    repeat (10) @(posedge clk);
    #1;
    chk++;
    if (intr_count != base) $display("FAIL sr_no_intr got %0d pulses want 0", intr_count - base); else pass++;
    axi_read(32'h18, d);
    chk++;
    if (d !== 32'h0) $display("FAIL sr_status_clear got %h want 00000000", d); else pass++;
    axi_write(32'h1C, 32'h0);
    run_image(16'h0100, at, pulses);
    chk++;
    if (at != 5 || pulses != 1) $display("FAIL sr_rerun_intr got at=%0d n=%0d want at=5 n=1", at, pulses); else pass++;
    axi_read(32'h08, d);
    chk++;
    if (d !== 32'h1) $display("FAIL sr_rerun_class got %h want 00000001", d); else pass++;
    for (int i = 0; i < 3; i++) begin
      axi_read(32'h14, d);
      chk++;
      if (d !== exp_out[i]) $display("FAIL sr_neuron_out%0d got %h want %h", i, d, exp_out[i]);
      else pass++;
    end
  endtask

  task automatic test_ignored_writes();
    logic [31:0] d;
    logic [31:0] exp_out [3];
    int at, pulses;
    exp_out = '{32'h0000_0400, 32'h0000_0800, 32'hFFFF_FC00};
    axi_write(32'h10, 32'h0);
    axi_write(32'h0C, 32'h2);
    axi_write(32'h00, 32'h7FFF);
    axi_write(32'h04, 32'h7FFF);
    axi_read(32'h0C, d);
    chk++;
    if (d !== 32'h2) $display("FAIL ign_layer_readback got %h want 00000002", d); else pass++;
    axi_write(32'h0C, 32'h1);
    axi_write(32'h10, 32'h5);
    axi_write(32'h00, 32'h7FFF);
    axi_write(32'h04, 32'h7FFF);
    axi_read(32'h10, d);
    chk++;
    if (d !== 32'h5) $display("FAIL ign_neuron_readback got %h want 00000005", d); else pass++;
    run_image(16'h0100, at, pulses);
    axi_read(32'h08, d);
    chk++;
    if (d !== 32'h1) $display("FAIL ign_class got %h want 00000001", d); else pass++;
    for (int i = 0; i < 3; i++) begin
      axi_read(32'h14, d);
      chk++;
      if (d !== exp_out[i]) $display("FAIL ign_neuron_out%0d got %h want %h", i, d, exp_out[i]);
      else pass++;
    end
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_inference();
    test_tie_sat();
    test_soft_reset();
    test_ignored_writes();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule

// File: doc/zy_net.md
Name: zy_net

Overview:
- AXI4-Lite-configured, AXI-stream-fed fully-connected classifier.
- It holds NUM_OUTPUTS neurons, each with NUM_INPUTS signed fixed-point weights and one bias, all written over AXI-Lite.
- For each image it consumes NUM_INPUTS pixels from the stream, computes every neuron output, then finds the argmax and raises a one-cycle interrupt.
- The processor reads the detected class and the per-neuron outputs back over AXI-Lite.

Parameters:
- DATA_WIDTH, 16, width of pixels, weights, biases and neuron outputs (signed, two's complement).
- NUM_INPUTS, 784, pixels per image and weights per neuron.
- NUM_OUTPUTS, 10, number of neurons/classes (max 256).
- FRAC_BITS, 8, fractional bits of the fixed-point format.

Ports:
- s_axi_aclk  in  1  single clock.
- s_axi_aresetn  in  1  asynchronous active-low reset.
- s_axi_awaddr  in  32  write address.
- s_axi_awprot  in  3  ignored.
- s_axi_awvalid/s_axi_awready  in/out  1  write-address handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  ignored; every write is full-word.
- s_axi_wvalid/s_axi_wready  in/out  1  write-data handshake.
- s_axi_bresp  out  2  always 0.
- s_axi_bvalid/s_axi_bready  out/in  1  write-response handshake.
- s_axi_araddr  in  32  read address.
- s_axi_arprot  in  3  ignored.
- s_axi_arvalid/s_axi_arready  in/out  1  read-address handshake.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  always 0.
- s_axi_rvalid/s_axi_rready  out/in  1  read-data handshake.
- axis_in_data  in  DATA_WIDTH  pixel.
- axis_in_data_valid/axis_in_data_ready  in/out  1  stream handshake.
- intr  out  1  one-cycle pulse when a classification completes.

Behaviour:

Reset:
- s_axi_aresetn low asynchronously clears all AXI outputs, intr, axis_in_data_ready, accumulators, pointers, status, the layer register and the neuron register.
- It sets SOFT_RESET to 1.
- Weight and bias memories are not reset.

AXI-Lite write path:
- A write is accepted only when awvalid and wvalid are both high and bvalid is low.
- On acceptance awready and wready pulse high together for exactly one cycle and the register write occurs.
- bvalid rises the next cycle and is held until bready.

AXI-Lite read path:
- When arvalid is high and rvalid is low, arready pulses for one cycle.
- On the next cycle rdata is registered and rvalid is held until rready.

Register map (decoded on addr[4:2]; unmapped reads return 0, unmapped writes are ignored):
- 0x00 W WEIGHT: when LAYER==1 and NEURON<NUM_OUTPUTS and wptr<NUM_INPUTS, w[NEURON][wptr] = wdata[DATA_WIDTH-1:0], then wptr increments. Otherwise the write is ignored.
- 0x04 W BIAS: when LAYER==1 and NEURON<NUM_OUTPUTS, b[NEURON] = wdata[DATA_WIDTH-1:0].
- 0x08 R OUT: detected class index, zero-extended.
- 0x0C RW LAYER: 32-bit layer number. Only layer 1 exists; WEIGHT/BIAS writes to any other layer are discarded.
- 0x10 RW NEURON: neuron select. Any write clears wptr to 0.
- 0x14 R NEURON_OUT: returns the sign-extended output of neuron rptr, then rptr increments, wrapping to 0 after NUM_OUTPUTS-1. rptr clears at the start of each image.
- 0x18 R STATUS: bit0 busy, bit1 done.
  - done sets with intr and clears when the next image's first pixel is accepted.
- 0x1C RW SOFT_RESET bit0, reset value 1.
  - While 1, the datapath is held idle: axis_in_data_ready=0, accumulators and pixel count cleared, status cleared, no intr.
  - Configuration registers and memories stay writable.

Datapath FSM (IDLE, ACCUM, FINAL, ARGMAX, DONE):
- IDLE/ACCUM: axis_in_data_ready=1 (when soft reset is clear). Each accepted beat k does acc[n] += (x*w[n][k]) >>> FRAC_BITS for all n in parallel.
  - The product is a 2*DATA_WIDTH-bit signed value; acc is a 32-bit signed value.
  - The first beat of an image enters ACCUM.
  - Accepting beat NUM_INPUTS-1 drops ready the following cycle and goes to FINAL.
- FINAL (1 cycle): out[n] = saturate(acc[n] + sign-extended b[n]) to DATA_WIDTH signed, i.e. clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Accumulators then clear.
- ARGMAX (NUM_OUTPUTS cycles): sequential scan. A strictly greater value replaces the best, so ties resolve to the lowest index.
- DONE (1 cycle): latch the OUT register, pulse intr, set done, return to IDLE with ready=1.
- busy is 1 in ACCUM, FINAL and ARGMAX.
- Valid without ready is stalled; no pixels are lost.
- Weight/bias writes during ACCUM take effect for subsequent beats.

Test Plan:
Use NUM_INPUTS=4, NUM_OUTPUTS=3, FRAC_BITS=8.
1. Reset: assert aresetn low -> all outputs 0, axis_in_data_ready 0; read 0x1C -> 1, read 0x18 -> 0.
2. Handshake: awvalid=1 with wvalid=0 for 5 cycles -> awready stays 0; then wvalid=1 -> awready/wready high for exactly 1 cycle; bvalid is held until bready.
3. Inference:
   - Setup: write 0x1C=0 and LAYER=1. Neuron 0 weights 4x0x0100, neuron 1 weights 4x0x0200, neuron 2 weights 4x0xFF00, all biases 0.
   - Stimulus: stream 4x0x0100.
   - Required: exactly one intr pulse, 5 cycles after the last accepted beat; OUT=1; NEURON_OUT reads 0x00000400, 0x00000800, 0xFFFFFC00, then 0x00000400 again (wrap).
4. Tie and saturation:
   - Tie: all weights 0, biases 0x0100 / 0x0200 / 0x0200 -> OUT=1.
   - Saturation: neuron 0 weights 0x7FFF with inputs 0x7FFF -> NEURON_OUT 0x00007FFF.
5. Soft reset mid-image: after 2 beats write 0x1C=1 -> ready drops, no intr. Clear soft reset and rerun scenario 3's stream -> identical results.
6. Ignored writes: LAYER=2, then write 0x00 and 0x04 -> the layer-1 result is unchanged. Write NEURON=5 then WEIGHT -> no memory change.
